// File: rtl/fifo_counted.sv
// fifo_counted: single-clock FIFO with an occupancy counter (all DEPTH
// slots usable), simultaneous read/write, watermarks, level output,
// synchronous flush and sticky overflow/underflow flags.
// data_out is show-ahead: the head word is visible without a read strobe.

module fifo_counted #(
  parameter int WIDTH         = 32,
  parameter int DEPTH_LOG2    = 2,
  parameter int AFULL_THRESH  = (1 << DEPTH_LOG2) - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  rd,
  output logic [WIDTH-1:0]      data_out,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full,
  output logic                  almost_empty,
  input  logic                  flush,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int PW    = DEPTH_LOG2;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);

  // Storage (never reset; only the pointers/count define validity)
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Control state
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  // Decoded per-cycle control
  logic empty_s;
  logic full_s;
  logic rd_ok_s;
  logic wr_ok_s;
  logic mem_we_s;
  logic ovf_set_s;
  logic unf_set_s;

  // Status decode and accept rules, all from the pre-edge count.
  // A write into a full FIFO is only legal when a read frees a slot
  // in the same cycle; a read of an empty FIFO is never accepted.
  always_comb begin
    empty_s = (count_q == CNT_ZERO);
    full_s  = (count_q == DEPTH_C);
    rd_ok_s = rd & ~empty_s;
    wr_ok_s = wr & (~full_s | rd_ok_s);
  end

  // Next-state for pointers, count and error flags; flush wins over rd/wr
  // and suppresses error detection for that cycle.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    mem_we_s  = 1'b0;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;

    if (flush) begin
      head_d  = PTR_ZERO;
      tail_d  = PTR_ZERO;
      count_d = CNT_ZERO;
    end else begin
      ovf_set_s = wr & ~wr_ok_s;
      unf_set_s = rd & empty_s;

      if (wr_ok_s) begin
        mem_we_s = 1'b1;
        tail_d   = tail_q + PTR_ONE;
      end else begin
        tail_d   = tail_q;
      end

      if (rd_ok_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end

      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        2'b11:   count_d = count_q;
        2'b00:   count_d = count_q;
        default: count_d = count_q;
      endcase
    end

    // Sticky flags: a new event in the same cycle as clear_err keeps the flag set.
    overflow_d  = ovf_set_s | (overflow_q  & ~clear_err);
    underflow_d = unf_set_s | (underflow_q & ~clear_err);
  end

  // Control register with asynchronous active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q      <= PTR_ZERO;
      tail_q      <= PTR_ZERO;
      count_q     <= CNT_ZERO;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write port; contents survive reset and flush by design
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[tail_q] <= data_in;
    end
  end

  // Output decode: status straight from count, show-ahead head word
  always_comb begin
    full         = full_s;
    empty        = empty_s;
    level        = count_q;
    almost_full  = (count_q >= AFULL_C);
    almost_empty = (count_q <= AEMPTY_C);
    overflow     = overflow_q;
    underflow    = underflow_q;
    if (empty_s) begin
      data_out = '0;
    end else begin
      data_out = mem_q[head_q];
    end
  end

endmodule

// File: tb/tb_fifo_counted.sv
// Directed testbench for fifo_counted (WIDTH=8, DEPTH_LOG2=2).

module tb_fifo_counted;

  logic       clk;
  logic       resetn;
  logic       wr;
  logic [7:0] data_in;
  logic       rd;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic [2:0] level;
  logic       almost_full;
  logic       almost_empty;
  logic       flush;
  logic       overflow;
  logic       underflow;
  logic       clear_err;

  int total = 0;
  int bad   = 0;

  fifo_counted #(
    .WIDTH(8),
    .DEPTH_LOG2(2)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .wr(wr),
    .data_in(data_in),
    .rd(rd),
    .data_out(data_out),
    .full(full),
    .empty(empty),
    .level(level),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .flush(flush),
    .overflow(overflow),
    .underflow(underflow),
    .clear_err(clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given request pattern; inputs are released
  // 1 time unit after the edge, where outputs are then sampled.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                     input logic f, input logic c);
    wr = w; data_in = d; rd = r; flush = f; clear_err = c;
    @(posedge clk);
    #1;
    wr = 1'b0; data_in = 8'h00; rd = 1'b0; flush = 1'b0; clear_err = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; wr = 1'b0; data_in = 8'h00; rd = 1'b0;
    flush = 1'b0; clear_err = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // 1: reset state
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_dout", 32'(data_out), 32'h00);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);

    // 2: fill, overflow, drain
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    chk("w1_level", 32'(level), 32'd1);
    chk("w1_dout", 32'(data_out), 32'h11);
    chk("w1_aempty", 32'(almost_empty), 32'd1);
    chk("w1_empty", 32'(empty), 32'd0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    chk("w2_level", 32'(level), 32'd2);
    chk("w2_aempty", 32'(almost_empty), 32'd0);
    chk("w2_afull", 32'(almost_full), 32'd0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    chk("w3_level", 32'(level), 32'd3);
    chk("w3_afull", 32'(almost_full), 32'd1);
    chk("w3_full", 32'(full), 32'd0);
    cyc(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    chk("w4_level", 32'(level), 32'd4);
    chk("w4_full", 32'(full), 32'd1);
    chk("w4_dout", 32'(data_out), 32'h11);
    cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("w5_level", 32'(level), 32'd4);
    chk("w5_ovf", 32'(overflow), 32'd1);
    chk("w5_dout", 32'(data_out), 32'h11);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("r1_dout", 32'(data_out), 32'h22);
    chk("r1_level", 32'(level), 32'd3);
    chk("r1_full", 32'(full), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("r2_dout", 32'(data_out), 32'h33);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("r3_dout", 32'(data_out), 32'h44);
    chk("r3_level", 32'(level), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("r4_empty", 32'(empty), 32'd1);
    chk("r4_dout", 32'(data_out), 32'h00);
    chk("r4_ovf_sticky", 32'(overflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 32'd0);

    // 3: full FIFO, simultaneous rd+wr, pointer wrap
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    chk("f_full", 32'(full), 32'd1);
    cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    chk("rw_level", 32'(level), 32'd4);
    chk("rw_ovf", 32'(overflow), 32'd0);
    chk("rw_dout", 32'(data_out), 32'h22);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("d1_dout", 32'(data_out), 32'h33);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("d2_dout", 32'(data_out), 32'h44);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("d3_dout", 32'(data_out), 32'h99);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("d4_empty", 32'(empty), 32'd1);
    chk("d4_unf", 32'(underflow), 32'd0);

    // 4: empty FIFO, simultaneous rd+wr; clear_err vs new event
    cyc(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    chk("erw_level", 32'(level), 32'd1);
    chk("erw_dout", 32'(data_out), 32'h5A);
    chk("erw_unf", 32'(underflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_unf", 32'(underflow), 32'd0);
    chk("clr_level", 32'(level), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("e_empty", 32'(empty), 32'd1);
    chk("e_unf", 32'(underflow), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("setwins_unf", 32'(underflow), 32'd1);

    // 5: flush with simultaneous write at level 3
    cyc(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
    chk("pf_level", 32'(level), 32'd3);
    cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    chk("fl_level", 32'(level), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_dout", 32'(data_out), 32'h00);
    chk("fl_unf", 32'(underflow), 32'd1);
    chk("fl_ovf", 32'(overflow), 32'd0);
    cyc(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    chk("pfw_dout", 32'(data_out), 32'hC3);
    chk("pfw_level", 32'(level), 32'd1);

    // 6: asynchronous reset between edges at level 2
    cyc(1'b1, 8'hC4, 1'b0, 1'b0, 1'b0);
    chk("pr_level", 32'(level), 32'd2);
    #3;
    resetn = 1'b0;
    #1;
    chk("ar_empty", 32'(empty), 32'd1);
    chk("ar_level", 32'(level), 32'd0);
    chk("ar_dout", 32'(data_out), 32'h00);
    chk("ar_unf", 32'(underflow), 32'd0);
    #2;
    resetn = 1'b1;
    cyc(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
    chk("post_dout", 32'(data_out), 32'hAB);
    chk("post_level", 32'(level), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
